// File: rtl/fifo_frame_reader.sv
// Consumer end of the sample FIFO: drains samples into a 2-entry skid buffer and
// presents them as a valid/ready stream tagged with frame position (sof/eof/index).
module fifo_frame_reader #(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 400,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    output logic             fifo_rd_en_o,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_read_data_i,
    output logic [WIDTH-1:0] sample_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             sof_o,
    output logic             eof_o,
    output logic [IDX_W-1:0] sample_idx_o,
    output logic [15:0]      frame_count_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic [WIDTH-1:0] buf_q [2];
    logic [1:0]       count_q;
    logic             inflight_q;
    logic [IDX_W-1:0] idx_q;
    logic [15:0]      frame_count_q;

    logic       pop;
    logic       is_last;
    logic [2:0] occupancy;

    assign valid_o  = (count_q != 2'd0);
    assign pop      = valid_o && ready_i;
    assign is_last  = (idx_q == LAST_IDX);

    // Entries held plus the one still in flight from the FIFO; a same-cycle pop frees
    // a slot, which is what lets reads continue back-to-back under ready_i=1.
    assign occupancy    = {1'b0, count_q} + {2'b00, inflight_q};
    assign fifo_rd_en_o = !rst && enable_i && !fifo_empty_i
                          && (occupancy < (3'd2 + {2'b00, pop}));

    assign sample_o      = buf_q[0];
    assign sample_idx_o  = idx_q;
    assign sof_o         = valid_o && (idx_q == '0);
    assign eof_o         = valid_o && is_last;
    assign frame_count_o = frame_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the two buffer entries are reset as well so sample_o reads 0 out of reset;
            // an in-flight read is dropped simply because inflight_q is cleared here.
            buf_q[0]      <= '0;
            buf_q[1]      <= '0;
            count_q       <= 2'd0;
            inflight_q    <= 1'b0;
            idx_q         <= '0;
            frame_count_q <= 16'd0;
        end else begin
            inflight_q <= fifo_rd_en_o;

            case ({inflight_q, pop})
                2'b10: begin
                    buf_q[count_q[0]] <= fifo_read_data_i;
                    count_q           <= count_q + 2'd1;
                end
                2'b01: begin
                    buf_q[0] <= buf_q[1];
                    count_q  <= count_q - 2'd1;
                end
                2'b11: begin
                    // Head leaves while the new sample lands behind whatever remains.
                    if (count_q == 2'd2) begin
                        buf_q[0] <= buf_q[1];
                        buf_q[1] <= fifo_read_data_i;
                    end else begin
                        buf_q[0] <= fifo_read_data_i;
                    end
                end
                default: ;
            endcase

            if (pop) begin
                idx_q <= is_last ? '0 : idx_q + IDX_W'(1);
                if (is_last) begin
                    frame_count_q <= frame_count_q + 16'd1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= 2'd2);
        end
    end

endmodule
